writeback_regfile: RTL and testbench
====================================

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- wb_en  input  1  commit strobe; one instruction commits per cycle with wb_en=1.
- icode  input  4  Y86 instruction code of the committing instruction.
- cnd  input  1  condition result from execute; gates cmovXX write.
- rA  input  4  register specifier A (4'hF = none).
- rB  input  4  register specifier B (4'hF = none).
- ValE  input  64  execute-stage result.
- ValM  input  64  memory-stage read data.
- adr_memory  input  1  memory-stage address error flag.
- ValA  output  64  combinational read of srcA register.
- ValB  output  64  combinational read of srcB register.
- stat  output  3  processor status: 1=AOK, 2=HLT, 3=ADR, 4=INS.
- retired  output  64  count of committed AOK instructions.

Function
REQ-002 Register file SHALL hold 15 registers of 64 bits, indices 0-14; index 15 (F) SHALL mean "no register" and SHALL read as 0.
REQ-003 srcA SHALL be rA for icode 2,4,6,A; 4 (%rsp) for icode 9,B; F otherwise.
REQ-004 srcB SHALL be rB for icode 4,5,6; 4 for icode 8,9,A,B; F otherwise.
REQ-005 ValA/ValB SHALL be combinational reads of srcA/srcB, reflecting register contents before the current edge's write (no write-through bypass).
REQ-006 dstE SHALL be rB for icode 3,6; rB for icode 2 only when cnd=1 (F when cnd=0); 4 for icode 8,9,A,B; F otherwise.
REQ-007 dstM SHALL be rA for icode 5,B; F otherwise.
REQ-008 On a rising edge with wb_en=1 and stat=AOK and no new fault (REQ-010), ValE SHALL be written to dstE and ValM to dstM; destination F SHALL be discarded.
REQ-009 When dstE==dstM (not F), the ValM write SHALL win (popq %rsp semantics).
REQ-010 Status FSM states AOK, HLT, ADR, INS; from AOK on a wb_en=1 edge, evaluated in priority: icode>4'hB -> INS; else adr_memory=1 -> ADR; else icode=0 -> HLT; else stay AOK.
REQ-011 HLT, ADR, INS SHALL be sticky until reset; no register writes and no retired increments SHALL occur in them.
REQ-012 A faulting instruction (INS or ADR) SHALL NOT write registers and SHALL NOT increment retired; a halt instruction SHALL increment retired and write nothing.
REQ-013 retired SHALL increment by 1 on each edge where wb_en=1, stat=AOK and the instruction does not fault; it SHALL wrap from 2^64-1 to 0.
REQ-014 wb_en=0 SHALL leave registers, stat and retired unchanged; icode and other inputs are don't-care except for ValA/ValB reads.

Reset
REQ-015 On a rising edge with rst_n=0: all 15 registers SHALL become 0, stat SHALL become AOK (1), retired SHALL become 0; reset SHALL override wb_en, including mid-operation and from sticky states.
REQ-016 rst_n SHALL have no effect between clock edges.

Verification
REQ-017 irmovq: wb_en=1, icode=3, rB=2, ValE=0x1234 -> next cycle, rB=2 reads ValB... srcB via icode=6 rB=2 gives ValB=0x1234; retired=1.
REQ-018 cmov: icode=2, rB=5, ValE=7, cnd=0 -> R5 stays 0; repeat with cnd=1 -> R5=7; retired=2.
REQ-019 popq %rsp: icode=B, rA=4, ValE=0x100, ValM=0xBEEF -> R4=0xBEEF.
REQ-020 Fault: icode=5, rA=3, ValM=9, adr_memory=1 -> stat=3, R3 unchanged, retired unchanged; a later icode=3 write is ignored.
REQ-021 Halt then invalid: icode=0 -> stat=2, retired+1; next icode=C -> stat stays 2; rst_n=0 one edge -> stat=1, retired=0, all registers 0.
REQ-022 Invalid opcode: icode=F from AOK -> stat=4, no write, retired unchanged.

Source files
------------

// File: rtl/writeback_regfile.sv
// Y86 writeback stage: 15x64 register file, sticky status FSM and retired-instruction counter.
// Reads are combinational with no bypass; writes, status and count update one edge after wb_en, with no backpressure.
module writeback_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_en,
  input  logic [3:0]  icode,
  input  logic        cnd,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic [63:0] ValE,
  input  logic [63:0] ValM,
  input  logic        adr_memory,
  output logic [63:0] ValA,
  output logic [63:0] ValB,
  output logic [2:0]  stat,
  output logic [63:0] retired
);

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'h4;

  typedef enum logic [2:0] {
    ST_AOK = 3'd1,
    ST_HLT = 3'd2,
    ST_ADR = 3'd3,
    ST_INS = 3'd4
  } stat_e;

  stat_e       r_state;
  stat_e       w_state_nxt;
  logic [63:0] r_regs [15];
  logic [63:0] r_retired;
  logic [3:0]  w_src_a;
  logic [3:0]  w_src_b;
  logic [3:0]  w_dst_e;
  logic [3:0]  w_dst_m;
  logic        w_fault;
  logic        w_commit;

  always_comb begin
    w_src_a = REG_NONE;
    w_src_b = REG_NONE;
    w_dst_e = REG_NONE;
    w_dst_m = REG_NONE;
    case (icode)
      4'h2:    begin w_src_a = rA; w_dst_e = cnd ? rB : REG_NONE; end
      4'h3:    w_dst_e = rB;
      4'h4:    begin w_src_a = rA; w_src_b = rB; end
      4'h5:    begin w_src_b = rB; w_dst_m = rA; end
      4'h6:    begin w_src_a = rA; w_src_b = rB; w_dst_e = rB; end
      4'h8:    begin w_src_b = REG_RSP; w_dst_e = REG_RSP; end
      4'h9:    begin w_src_a = REG_RSP; w_src_b = REG_RSP; w_dst_e = REG_RSP; end
      4'hA:    begin w_src_a = rA; w_src_b = REG_RSP; w_dst_e = REG_RSP; end
      4'hB:    begin w_src_a = REG_RSP; w_src_b = REG_RSP; w_dst_e = REG_RSP; w_dst_m = rA; end
      default: ;
    endcase
  end

  // Register 15 is not stored; it always reads as zero.
  assign ValA = (w_src_a == REG_NONE) ? 64'd0 : r_regs[w_src_a];
  assign ValB = (w_src_b == REG_NONE) ? 64'd0 : r_regs[w_src_b];

  assign w_fault  = (icode > 4'hB) || adr_memory;
  assign w_commit = wb_en && (r_state == ST_AOK) && !w_fault;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_AOK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (wb_en && (r_state == ST_AOK)) begin
      if (icode > 4'hB)       w_state_nxt = ST_INS;
      else if (adr_memory)    w_state_nxt = ST_ADR;
      else if (icode == 4'h0) w_state_nxt = ST_HLT;
      else                    w_state_nxt = ST_AOK;
    end
  end

  // Checking dstM first gives the memory value priority on popq %rsp.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) begin
        r_regs[i] <= 64'd0;
      end
    end else if (w_commit) begin
      for (int i = 0; i < 15; i++) begin
        if (w_dst_m == 4'(i)) begin
          r_regs[i] <= ValM;
        end else if (w_dst_e == 4'(i)) begin
          r_regs[i] <= ValE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_retired <= 64'd0;
    end else if (w_commit) begin
      r_retired <= r_retired + 64'd1;
    end
  end

  assign stat    = r_state;
  assign retired = r_retired;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: stimulus pushes expected read/status values to a queue,
// a negedge monitor pops and compares whenever the driver flags a sample cycle.
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_en = 1'b0;
  logic [3:0]  icode = 4'h1;
  logic        cnd = 1'b0;
  logic [3:0]  rA = 4'hF;
  logic [3:0]  rB = 4'hF;
  logic [63:0] ValE = 64'd0;
  logic [63:0] ValM = 64'd0;
  logic        adr_memory = 1'b0;
  logic [63:0] ValA;
  logic [63:0] ValB;
  logic [2:0]  stat;
  logic [63:0] retired;

  typedef struct {
    string       name;
    logic [63:0] val_a;
    logic [63:0] val_b;
    logic [2:0]  stat;
    logic [63:0] retired;
  } exp_t;

  exp_t exp_q[$];
  logic chk_vld = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  writeback_regfile dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_en      (wb_en),
    .icode      (icode),
    .cnd        (cnd),
    .rA         (rA),
    .rB         (rB),
    .ValE       (ValE),
    .ValM       (ValM),
    .adr_memory (adr_memory),
    .ValA       (ValA),
    .ValB       (ValB),
    .stat       (stat),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (chk_vld) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow: sample flagged with no expectation queued");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_checks++;
        if (ValA !== e.val_a) begin
          n_fail++;
          $display("FAIL %s.ValA: got %h expected %h", e.name, ValA, e.val_a);
        end
        n_checks++;
        if (ValB !== e.val_b) begin
          n_fail++;
          $display("FAIL %s.ValB: got %h expected %h", e.name, ValB, e.val_b);
        end
        n_checks++;
        if (stat !== e.stat) begin
          n_fail++;
          $display("FAIL %s.stat: got %0d expected %0d", e.name, stat, e.stat);
        end
        n_checks++;
        if (retired !== e.retired) begin
          n_fail++;
          $display("FAIL %s.retired: got %0d expected %0d", e.name, retired, e.retired);
        end
      end
    end
  end

  // One clock of stimulus; optionally queues an expectation sampled within this cycle.
  task automatic drive(input logic wb, input logic [3:0] ic, input logic c,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] ve, input logic [63:0] vm, input logic adr,
                       input logic chk, input string name,
                       input logic [63:0] ea, input logic [63:0] eb,
                       input logic [2:0] es, input logic [63:0] er);
    exp_t e;
    wb_en = wb; icode = ic; cnd = c; rA = ra; rB = rb;
    ValE = ve; ValM = vm; adr_memory = adr;
    if (chk) begin
      e.name = name; e.val_a = ea; e.val_b = eb; e.stat = es; e.retired = er;
      exp_q.push_back(e);
    end
    chk_vld = chk;
    @(posedge clk);
    #1;
    chk_vld = 1'b0;
    wb_en = 1'b0;
  endtask

  task automatic commit(input logic [3:0] ic, input logic c, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [63:0] ve, input logic [63:0] vm,
                        input logic adr);
    drive(1'b1, ic, c, ra, rb, ve, vm, adr, 1'b0, "", 64'd0, 64'd0, 3'd0, 64'd0);
  endtask

  // Reads rA/rB through icode 6 (OPq) with wb_en low.
  task automatic probe(input string name, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] ea, input logic [63:0] eb,
                       input logic [2:0] es, input logic [63:0] er);
    drive(1'b0, 4'h6, 1'b0, ra, rb, 64'd0, 64'd0, 1'b0, 1'b1, name, ea, eb, es, er);
  endtask

  task automatic pulse_reset(input logic wb);
    rst_n = 1'b0;
    drive(wb, 4'h3, 1'b0, 4'hF, 4'h1, 64'h77, 64'd0, 1'b0, 1'b0, "", 64'd0, 64'd0, 3'd0, 64'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    probe("reset", 4'h2, 4'h5, 64'd0, 64'd0, 3'd1, 64'd0);

    commit(4'h3, 1'b0, 4'hF, 4'h2, 64'h1234, 64'd0, 1'b0);
    probe("irmovq", 4'h2, 4'h5, 64'h1234, 64'd0, 3'd1, 64'd1);

    commit(4'h2, 1'b0, 4'h1, 4'h5, 64'd7, 64'd0, 1'b0);
    probe("cmov_nc", 4'hF, 4'h5, 64'd0, 64'd0, 3'd1, 64'd2);
    commit(4'h2, 1'b1, 4'h1, 4'h5, 64'd7, 64'd0, 1'b0);
    probe("cmov_c", 4'h5, 4'h2, 64'd7, 64'h1234, 3'd1, 64'd3);

    // Commit and sample in the same cycle: reads must show pre-edge contents.
    drive(1'b1, 4'h6, 1'b0, 4'h5, 4'h2, 64'h99, 64'd0, 1'b0, 1'b1, "no_bypass",
          64'd7, 64'h1234, 3'd1, 64'd3);
    probe("opq", 4'h2, 4'hF, 64'h99, 64'd0, 3'd1, 64'd4);

    commit(4'hB, 1'b0, 4'h4, 4'hF, 64'h100, 64'hBEEF, 1'b0);
    probe("popq_rsp", 4'h4, 4'hF, 64'hBEEF, 64'd0, 3'd1, 64'd5);

    drive(1'b1, 4'hA, 1'b0, 4'h2, 4'hF, 64'hF8, 64'd0, 1'b0, 1'b1, "pushq_src",
          64'h99, 64'hBEEF, 3'd1, 64'd5);
    probe("pushq_dst", 4'h4, 4'h2, 64'hF8, 64'h99, 3'd1, 64'd6);

    drive(1'b0, 4'h3, 1'b0, 4'hF, 4'h2, 64'hDEAD, 64'd0, 1'b0, 1'b0, "", 64'd0, 64'd0, 3'd0, 64'd0);
    probe("wb_en_low", 4'h2, 4'hF, 64'h99, 64'd0, 3'd1, 64'd6);

    commit(4'h5, 1'b0, 4'h3, 4'h2, 64'hAAAA, 64'h33, 1'b0);
    probe("mrmovq", 4'h3, 4'h2, 64'h33, 64'h99, 3'd1, 64'd7);

    commit(4'h5, 1'b0, 4'h3, 4'hF, 64'd0, 64'd9, 1'b1);
    probe("adr_fault", 4'h3, 4'hF, 64'h33, 64'd0, 3'd3, 64'd7);
    commit(4'h3, 1'b0, 4'hF, 4'h3, 64'd5, 64'd0, 1'b0);
    probe("adr_sticky", 4'h3, 4'hF, 64'h33, 64'd0, 3'd3, 64'd7);

    pulse_reset(1'b1);
    probe("reset_sticky", 4'h2, 4'h4, 64'd0, 64'd0, 3'd1, 64'd0);
    probe("reset_ovr_wb", 4'h1, 4'h3, 64'd0, 64'd0, 3'd1, 64'd0);

    commit(4'h3, 1'b0, 4'hF, 4'h1, 64'h11, 64'd0, 1'b0);
    commit(4'h0, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0, 1'b0);
    probe("halt", 4'h1, 4'hF, 64'h11, 64'd0, 3'd2, 64'd2);
    commit(4'hC, 1'b0, 4'hF, 4'h1, 64'h22, 64'd0, 1'b0);
    probe("halt_sticky", 4'h1, 4'hF, 64'h11, 64'd0, 3'd2, 64'd2);
    pulse_reset(1'b0);
    probe("halt_reset", 4'h1, 4'h2, 64'd0, 64'd0, 3'd1, 64'd0);

    commit(4'hF, 1'b1, 4'h1, 4'h1, 64'h55, 64'h55, 1'b0);
    probe("ins_fault", 4'h1, 4'hF, 64'd0, 64'd0, 3'd4, 64'd0);

    pulse_reset(1'b0);
    commit(4'hD, 1'b0, 4'h1, 4'h1, 64'h66, 64'h66, 1'b1);
    probe("ins_over_adr", 4'h1, 4'hF, 64'd0, 64'd0, 3'd4, 64'd0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(posedge clk);
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
